// File: rtl/timer_irq.sv
// ---------------------------------------------------------------------------
// timer_irq
//
// Bus-mapped countdown timer that drives one bit of the CPU external
// interrupt vector. Software programs CTRL, PRESET and COUNT over a small
// word-addressed bus. When COUNT expires, the timer raises either a level
// interrupt (one-shot) or a one-cycle pulse (auto-reload).
//
// Optional build macro: TIMER_PRESCALER_EN
//   When defined, COUNT steps once every PRESCALE clocks instead of every
//   clock.
//
// Ports
//   clk         in   1   clock
//   reset       in   1   synchronous, active-high reset
//   addr        in   2   word select: 0 CTRL, 1 PRESET, 2 COUNT, 3 reserved
//   writeEnable in   1   bus write strobe
//   writeData   in  32   bus write data
//   readData    out 32   combinational read of the selected register
//   irq         out  1   irqPending & CTRL.IM
//
// CTRL: [0] enable, [2:1] mode (1 = auto-reload, others one-shot),
//       [3] IM (1 = unmasked), [31:4] read as zero.
//
// State  | Meaning
// -------+---------------------------------------------------------------
// IDLE   | stopped, waiting for CTRL.enable
// LOAD   | COUNT <= PRESET, then count if still enabled
// CNT    | decrement COUNT on each tick; expire when COUNT is already 0
// INT    | expiry: one-shot clears enable; auto-reload reloads and recounts
// ---------------------------------------------------------------------------
module timer_irq #(
  parameter int PRESCALE = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  addr,
  input  logic        writeEnable,
  input  logic [31:0] writeData,
  output logic [31:0] readData,
  output logic        irq
);

  if (PRESCALE < 1) begin : g_bad_prescale
    $error("timer_irq: PRESCALE must be at least 1");
  end

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CNT  = 2'd2,
    ST_INT  = 2'd3
  } state_t;

  state_t      state_q;
  logic [3:0]  ctrl_q;
  logic [31:0] preset_q;
  logic [31:0] count_q;
  logic        irq_pending_q;

  logic        tick;
  logic        ctrl_we;
  logic        preset_we;
  logic        mode_auto;
  logic        pend_set;

  assign ctrl_we   = writeEnable && (addr == 2'd0);
  assign preset_we = writeEnable && (addr == 2'd1);
  assign mode_auto = (ctrl_q[2:1] == 2'b01);

  // Expiry on this edge: a simultaneous CTRL write must not cancel it.
  assign pend_set  = (state_q == ST_CNT) && ctrl_q[0] && tick && (count_q == 32'd0);

`ifdef TIMER_PRESCALER_EN
  localparam int DIV_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PRESCALE - 1);

  logic [DIV_W-1:0] div_q;

  assign tick = (div_q == DIV_LAST);

  // The divider only runs while counting; every other state parks it at 0,
  // so each fresh count starts a full PRESCALE period.
  always_ff @(posedge clk) begin
    if (reset) begin
      div_q <= '0;
    end else if (state_q == ST_CNT) begin
      div_q <= tick ? '0 : div_q + 1'b1;
    end else begin
      div_q <= '0;
    end
  end
`else
  assign tick = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      ctrl_q        <= 4'd0;
      preset_q      <= 32'd0;
      count_q       <= 32'd0;
      irq_pending_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (ctrl_q[0]) state_q <= ST_LOAD;
        end
        ST_LOAD: begin
          count_q <= preset_q;
          state_q <= ctrl_q[0] ? ST_CNT : ST_IDLE;
        end
        ST_CNT: begin
          if (!ctrl_q[0]) begin
            state_q <= ST_IDLE;
          end else if (tick) begin
            if (count_q == 32'd0) begin
              state_q       <= ST_INT;
              irq_pending_q <= 1'b1;
            end else begin
              count_q <= count_q - 32'd1;
            end
          end
        end
        ST_INT: begin
          if (mode_auto) begin
            // The reload is folded into the INT cycle so that pulses are
            // PRESET+2 cycles apart.
            irq_pending_q <= 1'b0;
            count_q       <= preset_q;
            state_q       <= ctrl_q[0] ? ST_CNT : ST_IDLE;
          end else begin
            ctrl_q[0] <= 1'b0;
            state_q   <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase

      if (preset_we) preset_q <= writeData;

      // Placed after the FSM so a bus write overrides the INT enable clear.
      if (ctrl_we) begin
        ctrl_q <= writeData[3:0];
        if (!pend_set) irq_pending_q <= 1'b0;
      end
    end
  end

  always_comb begin
    readData = 32'd0;
    case (addr)
      2'd0:    readData = {28'd0, ctrl_q};
      2'd1:    readData = preset_q;
      2'd2:    readData = count_q;
      default: readData = 32'd0;
    endcase
  end

  assign irq = irq_pending_q & ctrl_q[3];

endmodule

// File: tb/tb_timer_irq.sv
// ---------------------------------------------------------------------------
// tb_timer_irq
//
// Directed self-checking bench for timer_irq. Inputs change and outputs are
// sampled 1 time unit after the rising edge. "Edge En" in the comments is
// the n-th rising edge after the CTRL write that starts a scenario (E0).
// ---------------------------------------------------------------------------
module tb_timer_irq;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  addr;
  logic        writeEnable;
  logic [31:0] writeData;
  logic [31:0] readData;
  logic        irq;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  timer_irq #(.PRESCALE(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .addr       (addr),
    .writeEnable(writeEnable),
    .writeData  (writeData),
    .readData   (readData),
    .irq        (irq)
  );

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    addr        = a;
    writeData   = d;
    writeEnable = 1'b1;
    step(1);
    writeEnable = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] v);
    addr = a;
    #1;
    v = readData;
  endtask

  task automatic test_reset;
    logic [31:0] v;
    reset       = 1'b1;
    addr        = 2'd0;
    writeEnable = 1'b0;
    writeData   = 32'd0;
    step(3);
    reset = 1'b0;
    for (int a = 0; a < 4; a++) begin
      rd(2'(a), v);
      n_cmp++;
      if (v !== 32'd0) begin
        n_err++;
        $display("FAIL reset_read addr=%0d: got %h expected %h", a, v, 32'd0);
      end
    end
    n_cmp++;
    if (irq !== 1'b0) begin
      n_err++;
      $display("FAIL reset_irq: got %b expected 0", irq);
    end
  endtask

  task automatic test_oneshot;
    logic [31:0] v;
    bus_write(2'd1, 32'd3);
    rd(2'd1, v);
    n_cmp++;
    if (v !== 32'd3) begin
      n_err++;
      $display("FAIL oneshot_preset_rd: got %0d expected 3", v);
    end
    bus_write(2'd0, 32'h9);             // E0
    step(1);                            // E1 LOAD
    for (int i = 0; i < 4; i++) begin   // E2..E5
      step(1);
      rd(2'd2, v);
      n_cmp++;
      if (v !== 32'(3 - i)) begin
        n_err++;
        $display("FAIL oneshot_count i=%0d: got %0d expected %0d", i, v, 3 - i);
      end
      n_cmp++;
      if (irq !== 1'b0) begin
        n_err++;
        $display("FAIL oneshot_irq_early i=%0d: got %b expected 0", i, irq);
      end
    end
    step(1);                            // E6 INT
    n_cmp++;
    if (irq !== 1'b1) begin
      n_err++;
      $display("FAIL oneshot_irq_rise: got %b expected 1", irq);
    end
    step(1);                            // E7 enable cleared
    rd(2'd0, v);
    n_cmp++;
    if (v !== 32'h8) begin
      n_err++;
      $display("FAIL oneshot_ctrl_after: got %h expected 8", v);
    end
    step(3);
    n_cmp++;
    if (irq !== 1'b1) begin
      n_err++;
      $display("FAIL oneshot_irq_level: got %b expected 1", irq);
    end
    bus_write(2'd0, 32'h8);
    n_cmp++;
    if (irq !== 1'b0) begin
      n_err++;
      $display("FAIL oneshot_irq_clear: got %b expected 0", irq);
    end
  endtask

  task automatic test_autoreload;
    logic exp;
    bus_write(2'd1, 32'd2);
    bus_write(2'd0, 32'hB);             // E0
    for (int c = 1; c <= 28; c++) begin
      if (c == 11) begin                // PRESET=5 written on E11, mid-count
        addr        = 2'd1;
        writeData   = 32'd5;
        writeEnable = 1'b1;
      end
      step(1);
      writeEnable = 1'b0;
      exp = (c == 5) || (c == 9) || (c == 13) || (c == 20) || (c == 27);
      n_cmp++;
      if (irq !== exp) begin
        n_err++;
        $display("FAIL autoreload_irq c=%0d: got %b expected %b", c, irq, exp);
      end
    end
    bus_write(2'd0, 32'h0);
    n_cmp++;
    if (irq !== 1'b0) begin
      n_err++;
      $display("FAIL autoreload_stop_irq: got %b expected 0", irq);
    end
  endtask

  // Masked expiry, with IM set by a CTRL write on the very expiry edge:
  // the pending set beats the write's clear.
  task automatic test_masked_simul;
    logic [31:0] v;
    bus_write(2'd1, 32'd1);
    bus_write(2'd0, 32'h1);             // E0, IM = 0
    step(3);                            // E3: COUNT = 0
    rd(2'd2, v);
    n_cmp++;
    if (v !== 32'd0) begin
      n_err++;
      $display("FAIL masked_count: got %0d expected 0", v);
    end
    n_cmp++;
    if (irq !== 1'b0) begin
      n_err++;
      $display("FAIL masked_irq: got %b expected 0", irq);
    end
    bus_write(2'd0, 32'h9);             // E4: expiry and CTRL write together
    n_cmp++;
    if (irq !== 1'b1) begin
      n_err++;
      $display("FAIL simul_set_wins: got %b expected 1", irq);
    end
    step(1);                            // E5: INT clears enable
    rd(2'd0, v);
    n_cmp++;
    if (v !== 32'h8) begin
      n_err++;
      $display("FAIL simul_ctrl: got %h expected 8", v);
    end
    n_cmp++;
    if (irq !== 1'b1) begin
      n_err++;
      $display("FAIL simul_irq_hold: got %b expected 1", irq);
    end
    bus_write(2'd0, 32'h0);
    n_cmp++;
    if (irq !== 1'b0) begin
      n_err++;
      $display("FAIL simul_clear: got %b expected 0", irq);
    end
  endtask

  // PRESET = 0, then a CTRL write during INT overrides the enable clear.
  task automatic test_int_priority;
    logic [31:0] v;
    bus_write(2'd1, 32'd0);
    bus_write(2'd0, 32'h9);             // E0
    step(2);                            // E2
    n_cmp++;
    if (irq !== 1'b0) begin
      n_err++;
      $display("FAIL p0_irq_early: got %b expected 0", irq);
    end
    step(1);                            // E3
    n_cmp++;
    if (irq !== 1'b1) begin
      n_err++;
      $display("FAIL p0_irq_e3: got %b expected 1", irq);
    end
    bus_write(2'd0, 32'h9);             // E4, FSM in INT
    n_cmp++;
    if (irq !== 1'b0) begin
      n_err++;
      $display("FAIL intwr_irq_clear: got %b expected 0", irq);
    end
    rd(2'd0, v);
    n_cmp++;
    if (v !== 32'h9) begin
      n_err++;
      $display("FAIL intwr_ctrl: got %h expected 9", v);
    end
    step(2);                            // E6
    n_cmp++;
    if (irq !== 1'b0) begin
      n_err++;
      $display("FAIL intwr_irq_e6: got %b expected 0", irq);
    end
    step(1);                            // E7: second expiry
    n_cmp++;
    if (irq !== 1'b1) begin
      n_err++;
      $display("FAIL intwr_irq_e7: got %b expected 1", irq);
    end
    bus_write(2'd0, 32'h0);
  endtask

  task automatic test_disable_reset;
    logic [31:0] v;
    bus_write(2'd1, 32'd10);
    bus_write(2'd0, 32'h9);             // E0
    step(5);                            // E5: COUNT = 7
    rd(2'd2, v);
    n_cmp++;
    if (v !== 32'd7) begin
      n_err++;
      $display("FAIL disable_count_e5: got %0d expected 7", v);
    end
    bus_write(2'd0, 32'h8);             // E6: COUNT 6, enable cleared
    step(4);
    rd(2'd2, v);
    n_cmp++;
    if (v !== 32'd6) begin
      n_err++;
      $display("FAIL disable_hold: got %0d expected 6", v);
    end
    n_cmp++;
    if (irq !== 1'b0) begin
      n_err++;
      $display("FAIL disable_irq: got %b expected 0", irq);
    end
    bus_write(2'd0, 32'h9);             // R0
    step(1);                            // R1 still 6
    rd(2'd2, v);
    n_cmp++;
    if (v !== 32'd6) begin
      n_err++;
      $display("FAIL reenable_r1: got %0d expected 6", v);
    end
    step(1);                            // R2 reloaded
    rd(2'd2, v);
    n_cmp++;
    if (v !== 32'd10) begin
      n_err++;
      $display("FAIL reenable_reload: got %0d expected 10", v);
    end
    step(11);                           // R13 = R(PRESET+3)
    n_cmp++;
    if (irq !== 1'b1) begin
      n_err++;
      $display("FAIL reenable_irq: got %b expected 1", irq);
    end
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    n_cmp++;
    if (irq !== 1'b0) begin
      n_err++;
      $display("FAIL midreset_irq: got %b expected 0", irq);
    end
    for (int a = 0; a < 3; a++) begin
      rd(2'(a), v);
      n_cmp++;
      if (v !== 32'd0) begin
        n_err++;
        $display("FAIL midreset_read addr=%0d: got %h expected 0", a, v);
      end
    end
  endtask

  task automatic test_ignored_writes;
    logic [31:0] v;
    bus_write(2'd1, 32'd7);
    bus_write(2'd2, 32'hDEAD_BEEF);
    rd(2'd2, v);
    n_cmp++;
    if (v !== 32'd0) begin
      n_err++;
      $display("FAIL count_write_ignored: got %h expected 0", v);
    end
    bus_write(2'd3, 32'hFFFF_FFFF);
    rd(2'd3, v);
    n_cmp++;
    if (v !== 32'd0) begin
      n_err++;
      $display("FAIL rsvd_read: got %h expected 0", v);
    end
    rd(2'd1, v);
    n_cmp++;
    if (v !== 32'd7) begin
      n_err++;
      $display("FAIL preset_after_rsvd: got %h expected 7", v);
    end
    bus_write(2'd0, 32'hFFFF_FFF6);
    rd(2'd0, v);
    n_cmp++;
    if (v !== 32'h6) begin
      n_err++;
      $display("FAIL ctrl_upper_bits: got %h expected 6", v);
    end
    step(3);
    rd(2'd2, v);
    n_cmp++;
    if (v !== 32'd0) begin
      n_err++;
      $display("FAIL disabled_no_load: got %h expected 0", v);
    end
    bus_write(2'd0, 32'h0);
  endtask

  // Mode 3 behaves as one-shot; expiry edge depends on the prescaler build.
  task automatic test_prescale;
    logic [31:0] v;
    int exp_edge;
    logic exp;
`ifdef TIMER_PRESCALER_EN
    exp_edge = 2 + (1 + 1) * 4;
`else
    exp_edge = 1 + 3;
`endif
    bus_write(2'd1, 32'd1);
    bus_write(2'd0, 32'hF);             // E0
    for (int c = 1; c <= 14; c++) begin
      step(1);
      exp = (c >= exp_edge);
      n_cmp++;
      if (irq !== exp) begin
        n_err++;
        $display("FAIL prescale_irq c=%0d: got %b expected %b", c, irq, exp);
      end
    end
    rd(2'd0, v);
    n_cmp++;
    if (v !== 32'hE) begin
      n_err++;
      $display("FAIL mode3_ctrl: got %h expected e", v);
    end
    bus_write(2'd0, 32'h0);
  endtask

  initial begin
    test_reset();
    test_oneshot();
    test_autoreload();
    test_masked_simul();
    test_int_priority();
    test_disable_reset();
    test_ignored_writes();
    test_prescale();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
